// File: rtl/falling_object_mover_pkg.sv
// Shared definitions for the falling/horizontal object movers: state encoding,
// fixed-point format and screen bounds.
package falling_object_mover_pkg;

  typedef enum logic [1:0] {
    PARKED  = 2'd0,
    FALLING = 2'd1,
    EXITING = 2'd2
  } mover_state_t;

  localparam int FIXED_POINT_SHIFT = 6;
  localparam int Y_WIDTH           = 11;
  localparam int ACC_WIDTH         = Y_WIDTH + FIXED_POINT_SHIFT;
  localparam int SPEED_WIDTH       = 32;
  localparam int INITIAL_Y         = -64;
  localparam int BOTTOM_Y          = 479;
  localparam int RIGHT_X           = 639;

  function automatic logic signed [ACC_WIDTH-1:0] to_fixed(input int pixels);
    return ACC_WIDTH'(pixels * (1 << FIXED_POINT_SHIFT));
  endfunction

  // Park row and one-past-bottom row, both in accumulator format.
  localparam logic signed [ACC_WIDTH-1:0] ACC_PARK  = to_fixed(INITIAL_Y);
  localparam logic signed [ACC_WIDTH-1:0] ACC_FLOOR = to_fixed(BOTTOM_Y + 1);
  localparam logic signed [Y_WIDTH-1:0]   Y_LAST    = Y_WIDTH'(BOTTOM_Y);

endpackage

// File: rtl/falling_object_mover_accumulator.sv
// Signed fixed-point accumulator with load, enable and clamp to [min,max];
// the add is done one bit wider than the addend so it can never wrap.
module fp_sat_accumulator #(
  parameter int                        WIDTH       = 17,
  parameter int                        ADD_WIDTH   = 32,
  parameter logic signed [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load,
  input  logic signed [WIDTH-1:0]       load_value,
  input  logic                          enable,
  input  logic signed [ADD_WIDTH-1:0]   addend,
  input  logic signed [WIDTH-1:0]       min_value,
  input  logic signed [WIDTH-1:0]       max_value,
  output logic signed [WIDTH-1:0]       value
);

  localparam int SUM_WIDTH = ADD_WIDTH + 1;

  logic signed [SUM_WIDTH-1:0] value_ext;
  logic signed [SUM_WIDTH-1:0] addend_ext;
  logic signed [SUM_WIDTH-1:0] min_ext;
  logic signed [SUM_WIDTH-1:0] max_ext;
  logic signed [SUM_WIDTH-1:0] sum;
  logic signed [WIDTH-1:0]     clamped;

  // Widen all operands, add, then clamp back into the accumulator range.
  always_comb begin
    value_ext  = {{(SUM_WIDTH-WIDTH){value[WIDTH-1]}}, value};
    addend_ext = {addend[ADD_WIDTH-1], addend};
    min_ext    = {{(SUM_WIDTH-WIDTH){min_value[WIDTH-1]}}, min_value};
    max_ext    = {{(SUM_WIDTH-WIDTH){max_value[WIDTH-1]}}, max_value};
    sum        = value_ext + addend_ext;
    if (sum < min_ext) begin
      clamped = min_value;
    end else if (sum > max_ext) begin
      clamped = max_value;
    end else begin
      clamped = sum[WIDTH-1:0];
    end
  end

  // Accumulator register: reset, then load, then clamped add.
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= RESET_VALUE;
    end else if (load) begin
      value <= load_value;
    end else if (enable) begin
      value <= clamped;
    end else begin
      value <= value;
    end
  end

endmodule

// File: rtl/falling_object_mover.sv
// Vertical position engine for one falling object; integrates Y once per frame
// and emits a single retire pulse on screen exit or collision.
module falling_object_mover
  import falling_object_mover_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          startOfFrame,
  input  logic                          loadX,
  input  logic signed [Y_WIDTH-1:0]     xIn,
  input  logic                          visible,
  input  logic signed [SPEED_WIDTH-1:0] speed,
  input  logic                          freeze,
  input  logic                          collision,
  output logic signed [Y_WIDTH-1:0]     topLeftX,
  output logic signed [Y_WIDTH-1:0]     topLeftY,
  output logic                          exceed,
  output logic                          active
);

  mover_state_t                  state;
  logic signed [ACC_WIDTH-1:0]   acc;
  logic                          exit_now;
  logic                          retire;
  logic                          acc_load;
  logic                          acc_enable;

  assign topLeftY = acc[ACC_WIDTH-1:FIXED_POINT_SHIFT];

  // Exit uses the registered position, so exceed trails the crossing frame by one cycle.
  always_comb begin
    exit_now   = (state == FALLING) && (topLeftY > Y_LAST);
    retire     = (state == FALLING) && (exit_now || collision);
    acc_load   = (state == PARKED) || ((state == EXITING) && !visible);
    acc_enable = (state == FALLING) && startOfFrame && !freeze && !retire;
  end

  fp_sat_accumulator #(
    .WIDTH       (ACC_WIDTH),
    .ADD_WIDTH   (SPEED_WIDTH),
    .RESET_VALUE (ACC_PARK)
  ) u_acc (
    .clk        (clk),
    .reset      (reset),
    .load       (acc_load),
    .load_value (ACC_PARK),
    .enable     (acc_enable),
    .addend     (speed),
    .min_value  (ACC_PARK),
    .max_value  (ACC_FLOOR),
    .value      (acc)
  );

  // Mover FSM with registered X, exceed and active outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= PARKED;
      topLeftX <= '0;
      exceed   <= 1'b0;
      active   <= 1'b0;
    end else begin
      case (state)
        PARKED: begin
          exceed <= 1'b0;
          if (loadX) begin
            topLeftX <= xIn;
          end else begin
            topLeftX <= topLeftX;
          end
          if (visible) begin
            state  <= FALLING;
            active <= 1'b1;
          end else begin
            state  <= PARKED;
            active <= 1'b0;
          end
        end
        FALLING: begin
          // A pending retire outranks a simultaneous visible drop.
          if (retire) begin
            state  <= EXITING;
            exceed <= 1'b1;
            active <= 1'b0;
          end else if (!visible) begin
            state  <= PARKED;
            exceed <= 1'b0;
            active <= 1'b0;
          end else begin
            state  <= FALLING;
            exceed <= 1'b0;
            active <= 1'b1;
          end
        end
        EXITING: begin
          exceed <= 1'b0;
          active <= 1'b0;
          if (!visible) begin
            state <= PARKED;
          end else begin
            state <= EXITING;
          end
        end
        default: begin
          state  <= PARKED;
          exceed <= 1'b0;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_falling_object_mover.sv
// Self-checking bench for falling_object_mover: directed scenarios plus a
// randomized run against an integer fixed-point reference model.
module tb_falling_object_mover;

  logic               clk;
  logic               reset;
  logic               startOfFrame;
  logic               loadX;
  logic signed [10:0] xIn;
  logic               visible;
  logic signed [31:0] speed;
  logic               freeze;
  logic               collision;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic               exceed;
  logic               active;

  int total = 0;
  int bad   = 0;
  int pulses = 0;

  falling_object_mover dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .loadX        (loadX),
    .xIn          (xIn),
    .visible      (visible),
    .speed        (speed),
    .freeze       (freeze),
    .collision    (collision),
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY),
    .exceed       (exceed),
    .active       (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exceed === 1'b1) pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; startOfFrame = 1'b0; loadX = 1'b0; xIn = '0; visible = 1'b0;
    speed = '0; freeze = 1'b0; collision = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if ($signed(topLeftY) !== -64) begin bad++; $display("FAIL reset_y got=%0d exp=%0d", topLeftY, -64); end
    total++; if ($signed(topLeftX) !== 0) begin bad++; $display("FAIL reset_x got=%0d exp=0", topLeftX); end
    total++; if (exceed !== 1'b0) begin bad++; $display("FAIL reset_exceed got=%b exp=0", exceed); end
    total++; if (active !== 1'b0) begin bad++; $display("FAIL reset_active got=%b exp=0", active); end
  endtask

  task automatic test_spawn_exit();
    int p0;
    do_reset();
    loadX = 1'b1; xIn = 11'sd100; tick();
    total++; if ($signed(topLeftX) !== 100) begin bad++; $display("FAIL park_loadx got=%0d exp=100", topLeftX); end
    visible = 1'b1; xIn = 11'sd304; speed = 32'sd128; tick();
    total++; if ($signed(topLeftX) !== 304) begin bad++; $display("FAIL rise_loadx got=%0d exp=304", topLeftX); end
    total++; if (active !== 1'b1) begin bad++; $display("FAIL fall_active got=%b exp=1", active); end
    xIn = 11'sd5; tick(); loadX = 1'b0;
    total++; if ($signed(topLeftX) !== 304) begin bad++; $display("FAIL fall_loadx_ignored got=%0d exp=304", topLeftX); end
    p0 = pulses;
    for (int f = 1; f <= 272; f++) begin
      frame();
      total++; if ($signed(topLeftY) !== -64 + 2 * f) begin bad++; $display("FAIL fall_y frame=%0d got=%0d exp=%0d", f, topLeftY, -64 + 2 * f); end
    end
    total++; if (exceed !== 1'b0) begin bad++; $display("FAIL exceed_early got=%b exp=0", exceed); end
    tick();
    total++; if (exceed !== 1'b1) begin bad++; $display("FAIL exit_exceed got=%b exp=1", exceed); end
    total++; if (active !== 1'b0) begin bad++; $display("FAIL exiting_active got=%b exp=0", active); end
    tick();
    total++; if (exceed !== 1'b0) begin bad++; $display("FAIL exceed_width got=%b exp=0", exceed); end
    total++; if ($signed(topLeftY) !== 480) begin bad++; $display("FAIL exiting_y got=%0d exp=480", topLeftY); end
    visible = 1'b0; tick();
    total++; if ($signed(topLeftY) !== -64) begin bad++; $display("FAIL ack_y got=%0d exp=-64", topLeftY); end
    total++; if (pulses - p0 !== 1) begin bad++; $display("FAIL exit_pulses got=%0d exp=1", pulses - p0); end
    visible = 1'b1; tick();
    total++; if (active !== 1'b1) begin bad++; $display("FAIL restart_active got=%b exp=1", active); end
    frame();
    total++; if ($signed(topLeftY) !== -62) begin bad++; $display("FAIL restart_y got=%0d exp=-62", topLeftY); end
    total++; if (exceed !== 1'b0) begin bad++; $display("FAIL restart_exceed got=%b exp=0", exceed); end
  endtask

  task automatic test_collision();
    int p0;
    do_reset();
    visible = 1'b1; tick();
    speed = 32'sh7FFFFFFF; p0 = pulses;
    frame();
    total++; if ($signed(topLeftY) !== 480) begin bad++; $display("FAIL sat_high_y got=%0d exp=480", topLeftY); end
    collision = 1'b1; tick(); collision = 1'b0;
    total++; if (exceed !== 1'b1) begin bad++; $display("FAIL race_exceed got=%b exp=1", exceed); end
    tick(); tick();
    total++; if (pulses - p0 !== 1) begin bad++; $display("FAIL race_pulses got=%0d exp=1", pulses - p0); end
    visible = 1'b0; tick();
    visible = 1'b1; tick();
    speed = 32'sd10496; p0 = pulses;
    frame();
    total++; if ($signed(topLeftY) !== 100) begin bad++; $display("FAIL mid_y got=%0d exp=100", topLeftY); end
    collision = 1'b1; tick(); collision = 1'b0;
    total++; if (exceed !== 1'b1) begin bad++; $display("FAIL mid_exceed got=%b exp=1", exceed); end
    frame(); frame(); frame();
    total++; if ($signed(topLeftY) !== 100) begin bad++; $display("FAIL mid_frozen got=%0d exp=100", topLeftY); end
    total++; if (pulses - p0 !== 1) begin bad++; $display("FAIL mid_pulses got=%0d exp=1", pulses - p0); end
  endtask

  task automatic test_freeze_fraction();
    int p0;
    do_reset();
    visible = 1'b1; tick();
    speed = 32'sd32;
    frame();
    total++; if ($signed(topLeftY) !== -64) begin bad++; $display("FAIL half_px_1 got=%0d exp=-64", topLeftY); end
    frame();
    total++; if ($signed(topLeftY) !== -63) begin bad++; $display("FAIL half_px_2 got=%0d exp=-63", topLeftY); end
    freeze = 1'b1;
    for (int f = 0; f < 10; f++) frame();
    total++; if ($signed(topLeftY) !== -63) begin bad++; $display("FAIL freeze_y got=%0d exp=-63", topLeftY); end
    p0 = pulses;
    collision = 1'b1; tick(); collision = 1'b0;
    total++; if (exceed !== 1'b1) begin bad++; $display("FAIL freeze_collision got=%b exp=1", exceed); end
    tick();
    total++; if (pulses - p0 !== 1) begin bad++; $display("FAIL freeze_pulses got=%0d exp=1", pulses - p0); end
    freeze = 1'b0;
  endtask

  task automatic test_saturation_low();
    do_reset();
    visible = 1'b1; tick();
    speed = 32'sd256; frame();
    total++; if ($signed(topLeftY) !== -60) begin bad++; $display("FAIL sat_low_pre got=%0d exp=-60", topLeftY); end
    speed = -32'sd640; frame();
    total++; if ($signed(topLeftY) !== -64) begin bad++; $display("FAIL sat_low_y got=%0d exp=-64", topLeftY); end
    total++; if (active !== 1'b1) begin bad++; $display("FAIL sat_low_active got=%b exp=1", active); end
  endtask

  task automatic test_midop_reset();
    int p0;
    do_reset();
    loadX = 1'b1; xIn = 11'sd77; visible = 1'b1; tick(); loadX = 1'b0;
    speed = 32'sd16896; frame();
    total++; if ($signed(topLeftY) !== 200) begin bad++; $display("FAIL pre_reset_y got=%0d exp=200", topLeftY); end
    reset = 1'b1; visible = 1'b0; tick(); reset = 1'b0;
    total++; if ($signed(topLeftY) !== -64) begin bad++; $display("FAIL midreset_y got=%0d exp=-64", topLeftY); end
    total++; if ($signed(topLeftX) !== 0) begin bad++; $display("FAIL midreset_x got=%0d exp=0", topLeftX); end
    total++; if (active !== 1'b0 || exceed !== 1'b0) begin bad++; $display("FAIL midreset_flags got=%b%b exp=00", active, exceed); end
    visible = 1'b1; tick();
    speed = 32'sd128; frame(); p0 = pulses;
    visible = 1'b0; tick();
    total++; if (active !== 1'b0) begin bad++; $display("FAIL drop_active got=%b exp=0", active); end
    tick();
    total++; if ($signed(topLeftY) !== -64) begin bad++; $display("FAIL drop_y got=%0d exp=-64", topLeftY); end
    total++; if (pulses - p0 !== 0) begin bad++; $display("FAIL drop_pulses got=%0d exp=0", pulses - p0); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      longint acc;
      int     exp_x;
      int     exp_y;
      int     sp;
      int     nframes;
      int     p0;
      bit     exited;
      bit     frz;
      do_reset();
      exp_x = int'($urandom_range(0, 2047)) - 1024;
      xIn = 11'(exp_x); loadX = 1'b1; visible = 1'b1; tick(); loadX = 1'b0;
      total++; if ($signed(topLeftX) !== exp_x) begin bad++; $display("FAIL rand_x it=%0d got=%0d exp=%0d", it, topLeftX, exp_x); end
      acc = -4096; exited = 1'b0; p0 = pulses;
      nframes = int'($urandom_range(5, 40));
      for (int f = 0; f < nframes; f++) begin
        sp = int'($urandom_range(0, 3200)) - 200;
        frz = ($urandom_range(0, 3) == 0);
        speed = sp; freeze = frz;
        frame(); tick();
        if (!exited && !frz) begin
          acc = acc + sp;
          if (acc < -4096) acc = -4096;
          if (acc > 30720) acc = 30720;
        end
        exp_y = int'(acc >>> 6);
        total++; if ($signed(topLeftY) !== exp_y) begin bad++; $display("FAIL rand_y it=%0d f=%0d got=%0d exp=%0d", it, f, topLeftY, exp_y); end
        if (exp_y > 479) exited = 1'b1;
      end
      freeze = 1'b0;
      total++; if (pulses - p0 !== int'(exited)) begin bad++; $display("FAIL rand_pulses it=%0d got=%0d exp=%0d", it, pulses - p0, exited); end
      visible = 1'b0; tick(); tick();
      total++; if ($signed(topLeftY) !== -64) begin bad++; $display("FAIL rand_park it=%0d got=%0d exp=-64", it, topLeftY); end
    end
  endtask

  initial begin
    test_reset();
    test_spawn_exit();
    test_collision();
    test_freeze_fraction();
    test_saturation_low();
    test_midop_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/falling_object_mover.md
Name: falling_object_mover

Overview:
- Position engine for one falling object, paired 1:1 with the per-object spawn FSM.
- Consumes loadX/topLeftX, visible and speed from the spawn FSM.
- Integrates vertical position once per video frame in fixed point.
- Returns the one-cycle exceed pulse that retires the object, on screen exit or on collision.
- Drives topLeftX/topLeftY to the object's draw/collision logic.

Parameters:
- INITIAL_Y, -64: park row (pixels); object starts fully above the screen.
- BOTTOM_Y, 479: last visible row; exit when topLeftY > BOTTOM_Y.
- FIXED_POINT_SHIFT, 6: fraction bits of the Y accumulator; speed is in 1/64 px per frame.
- Y_WIDTH, 11: signed integer width of topLeftX/topLeftY.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse per video frame
- loadX  in  1  latch xIn while PARKED
- xIn  in  11 signed  spawn X from the spawn FSM
- visible  in  1  object enabled (high = moving)
- speed  in  32 signed (int)  Y increment per frame, fixed point
- freeze  in  1  pause motion (game paused); position held
- collision  in  1  pulse: object hit the player
- topLeftX  out  11 signed  latched X
- topLeftY  out  11 signed  integer part of the Y accumulator
- exceed  out  1  one-cycle retire pulse to the spawn FSM
- active  out  1  high in FALLING

Behaviour:
- Reset, synchronous, highest priority, usable mid-operation:
  - state = PARKED.
  - Y accumulator = INITIAL_Y << 6.
  - topLeftX = 0; exceed = 0; active = 0.
- Y accumulator: 17-bit signed (11 integer + 6 fraction bits); topLeftY = accumulator >>> 6.
- PARKED:
  - Each cycle loadX=1, register topLeftX <= xIn.
  - Accumulator held at INITIAL_Y << 6.
  - visible=1 -> FALLING next cycle.
  - The cycle visible rises, loadX is still honoured.
- FALLING:
  - active=1; loadX ignored.
  - On startOfFrame with freeze=0: accumulator <= accumulator + speed, computed at 32 bits.
  - Result saturates to [INITIAL_Y<<6, (BOTTOM_Y+1)<<6].
  - Negative speed therefore never rises above the park row.
  - Exit check uses the registered accumulator: topLeftY > BOTTOM_Y -> exceed=1 that cycle, state -> EXITING.
  - Exceed latency is one cycle after the frame update that crossed the bottom.
  - collision=1 -> exceed=1 that cycle, state -> EXITING.
  - Collision and exit in the same cycle produce a single exceed pulse.
  - visible=0 without an exit condition -> PARKED, no exceed.
  - visible drop while exceed is pending: exceed wins, pulse still issued.
- EXITING:
  - exceed=0; position frozen.
  - Waits for visible=0, the spawn FSM ack, normally 1 cycle later.
  - Then -> PARKED with the accumulator reset to the park row.
  - If visible remains 1, stays in EXITING indefinitely; no second pulse.
- exceed is registered, never high on two consecutive cycles, and only ever asserted out of FALLING.
- freeze=1 blocks accumulation only. Collision is still honoured; visible and startOfFrame still behave normally.
- startOfFrame arriving in PARKED or EXITING is ignored.

Decomposition:
- Shared game package holds:
  - mover_state_t enum {PARKED, FALLING, EXITING}.
  - FIXED_POINT_SHIFT and the screen bounds (BOTTOM_Y=479, RIGHT_X=639).
  - Shared with the other movers.
- One sub-module, fp_sat_accumulator:
  - Signed add with clamp to [min,max].
  - Load and enable inputs.
  - Reusable by the horizontal movers.

Test Plan:
- Spawn/exit: reset; loadX with xIn=304; visible=1; speed=128; run frames. topLeftX=304 and topLeftY steps -64,-62,… After 272 frames topLeftY=480; exceed exactly one cycle later for 1 cycle; state EXITING.
- Ack: after exceed, drop visible next cycle -> topLeftY=-64 and active=0 next cycle. Raise visible again -> fall restarts from -64 with no stale exceed.
- Collision race: collision pulse on the same cycle Y crosses 480 -> exactly one exceed pulse. Collision mid-screen at Y=100 -> exceed, position frozen at 100.
- Freeze/fraction: speed=32 (0.5 px/frame). Two frames -> Y advances 1 px. With freeze=1 for 10 frames, Y unchanged; collision during freeze still gives exceed.
- Saturation: speed=-640 from Y=-60 -> clamps to -64. speed=0x7FFFFFFF -> clamps to 480, then one exceed.
- Mid-op reset: reset asserted while FALLING at Y=200 -> next cycle Y=-64, X=0, exceed=0, PARKED. visible=0 mid-fall -> PARKED, no exceed.
